mem_bus_arbiter: RTL and testbench

Two-master arbiter placed in front of the memory controller's single bus port (bus_addr/bus_wrdata/bus_wren/bus_rddata). It shares the ROM/RAM/GPIO/UART address space between the RV32I core data port (master 0) and a secondary master (master 1, the UART boot loader that writes program images into RAM). It grants one transfer per cycle with round-robin fairness and a burst cap, and returns read data to the correct master after a fixed memory read latency.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/rd_tag_pipe.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory bus arbiter.
//   RV32I_OPERAND_t : 32-bit address/data word.
//   ARB_STATE_t     : arbiter FSM state (IDLE, OWN0, OWN1).
//   ARB_MASTER_t    : 1-bit master id (0 = core data port, 1 = boot loader).
//   RD_TAG_t        : read-response tag {valid, id} carried down the read pipe.
package mem_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } ARB_STATE_t;

  typedef logic ARB_MASTER_t;

  typedef struct packed {
    logic        valid;
    ARB_MASTER_t id;
  } RD_TAG_t;

  localparam RD_TAG_t RD_TAG_NONE = '{valid: 1'b0, id: 1'b0};

  // Build the tag pushed for one cycle: a real tag only for a granted read.
  function automatic RD_TAG_t make_rd_tag(input logic is_read, input ARB_MASTER_t id);
    RD_TAG_t t;
    t.valid = is_read;
    t.id    = is_read ? id : 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LATENCY-deep shift register of read tags.
//   clk     in  : system clock, rising edge
//   rst     in  : synchronous active-high reset, clears every stage to invalid
//   tag_in  in  : tag issued this cycle (invalid when no read was granted)
//   tag_out out : tag issued RD_LATENCY cycles ago
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  RD_TAG_t tag_in,
  output RD_TAG_t tag_out
);

  RD_TAG_t stage_q [RD_LATENCY];
  RD_TAG_t stage_d [RD_LATENCY];

  // Shift by one stage; stage 0 takes the newly issued tag.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= RD_TAG_NONE;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter with burst cap in front of
// the memory controller's single bus port.
//   clk, rst                      : clock, synchronous active-high reset
//   mX_req/addr/wrdata/wren  in   : master X transfer request (held until granted)
//   mX_gnt                   out  : transfer performed for master X this cycle
//   mX_rdvalid/rddata        out  : read response for master X (rddata 0 when not valid)
//   bus_addr/wrdata/wren     out  : to memory controller (0 when nothing granted)
//   bus_rddata               in   : read data, valid RD_LATENCY cycles after a granted read
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wrdata,
  input  logic        m0_wren,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wrdata,
  input  logic        m1_wren,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rdvalid,
  output logic        m1_rdvalid,
  output logic [31:0] m0_rddata,
  output logic [31:0] m1_rddata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic        bus_wren,
  input  logic [31:0] bus_rddata
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  ARB_STATE_t    state_q, state_d;
  ARB_MASTER_t   last_owner_q, last_owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  logic       gnt0_s, gnt1_s;
  logic       own_req_s, oth_req_s;
  ARB_STATE_t oth_state_s;
  RD_TAG_t    tag_in_s, tag_out_s;

  // Grants follow ownership; rst gating keeps every output quiet during reset,
  // including the cycle in which rst is first sampled.
  always_comb begin
    gnt0_s = !rst && (state_q == OWN0) && m0_req;
    gnt1_s = !rst && (state_q == OWN1) && m1_req;
    m0_gnt = gnt0_s;
    m1_gnt = gnt1_s;
  end

  // Bus mux: granted master's transfer, otherwise all zero.
  always_comb begin
    if (gnt0_s) begin
      bus_addr   = m0_addr;
      bus_wrdata = m0_wrdata;
      bus_wren   = m0_wren;
    end else if (gnt1_s) begin
      bus_addr   = m1_addr;
      bus_wrdata = m1_wrdata;
      bus_wren   = m1_wren;
    end else begin
      bus_addr   = 32'h0000_0000;
      bus_wrdata = 32'h0000_0000;
      bus_wren   = 1'b0;
    end
  end

  // Owner/other request view so OWN0 and OWN1 share one set of rules.
  always_comb begin
    if (state_q == OWN1) begin
      own_req_s   = m1_req;
      oth_req_s   = m0_req;
      oth_state_s = OWN0;
    end else begin
      own_req_s   = m0_req;
      oth_req_s   = m1_req;
      oth_state_s = OWN1;
    end
  end

  // Next-state logic: round robin on ties, burst cap only while contested.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (gnt0_s) begin
      last_owner_d = 1'b0;
    end else if (gnt1_s) begin
      last_owner_d = 1'b1;
    end else begin
      last_owner_d = last_owner_q;
    end
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (m0_req && m1_req) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (oth_req_s && (!own_req_s || burst_cnt_q == BURST_LAST)) begin
          state_d     = oth_state_s;
          burst_cnt_d = '0;
        end else if (!own_req_s && !oth_req_s) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else if (oth_req_s) begin
          // Owner granted while the other master waits: count toward the cap.
          burst_cnt_d = burst_cnt_q + BW'(1);
        end else begin
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // FSM registers; last_owner resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Tag issued this cycle: id 1 only when master 1 holds the grant.
  always_comb begin
    if (gnt0_s) begin
      tag_in_s = make_rd_tag(!m0_wren, 1'b0);
    end else if (gnt1_s) begin
      tag_in_s = make_rd_tag(!m1_wren, 1'b1);
    end else begin
      tag_in_s = RD_TAG_NONE;
    end
  end

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in_s),
    .tag_out(tag_out_s)
  );

  // Response demux: returning data goes only to the master named in the tag.
  always_comb begin
    m0_rdvalid = !rst && tag_out_s.valid && (tag_out_s.id == 1'b0);
    m1_rdvalid = !rst && tag_out_s.valid && (tag_out_s.id == 1'b1);
    m0_rddata  = m0_rdvalid ? bus_rddata : 32'h0000_0000;
    m1_rddata  = m1_rdvalid ? bus_rddata : 32'h0000_0000;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (RD_LATENCY 1, 2, 3) share one
// stimulus stream; a cycle model checks every output each cycle and directed
// literal expectations pin the model.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wd0, wd1, bus_rd;

  logic        g0 [1:3];
  logic        g1 [1:3];
  logic        v0 [1:3];
  logic        v1 [1:3];
  logic [31:0] rd0 [1:3];
  logic [31:0] rd1 [1:3];
  logic [31:0] ba [1:3];
  logic [31:0] bwd [1:3];
  logic        bwe [1:3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar L = 1; L <= 3; L++) begin : g_dut
    mem_bus_arbiter #(.RD_LATENCY(L), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(req0), .m0_addr(addr0), .m0_wrdata(wd0), .m0_wren(we0),
      .m1_req(req1), .m1_addr(addr1), .m1_wrdata(wd1), .m1_wren(we1),
      .m0_gnt(g0[L]), .m1_gnt(g1[L]),
      .m0_rdvalid(v0[L]), .m1_rdvalid(v1[L]),
      .m0_rddata(rd0[L]), .m1_rddata(rd1[L]),
      .bus_addr(ba[L]), .bus_wrdata(bwd[L]), .bus_wren(bwe[L]),
      .bus_rddata(bus_rd)
    );
  end

  function automatic logic [132:0] act_vec(input int L);
    return {g0[L], g1[L], v0[L], v1[L], rd0[L], rd1[L], ba[L], bwd[L], bwe[L]};
  endfunction

  // ---------------- behavioural model ----------------
  // owner: -1 none, else master id; run: grants given to owner while the
  // other master was waiting; hist[k]: master whose read was issued k+1 cycles ago.
  int owner = -1;
  int last  = 1;
  int run   = 0;
  int hist [3] = '{-1, -1, -1};

  logic        e_g0, e_g1, e_v0, e_v1, e_we;
  logic [31:0] e_rd0, e_rd1, e_ba, e_bwd;
  logic [132:0] exp_v, got_v;
  int gid, newtag, oth;
  logic r [2];

  always @(negedge clk) begin
    e_g0 = !rst && owner == 0 && req0;
    e_g1 = !rst && owner == 1 && req1;
    if (e_g0) begin
      e_ba = addr0; e_bwd = wd0; e_we = we0;
    end else if (e_g1) begin
      e_ba = addr1; e_bwd = wd1; e_we = we1;
    end else begin
      e_ba = 32'h0; e_bwd = 32'h0; e_we = 1'b0;
    end
    for (int L = 1; L <= 3; L++) begin
      e_v0  = !rst && hist[L-1] == 0;
      e_v1  = !rst && hist[L-1] == 1;
      e_rd0 = e_v0 ? bus_rd : 32'h0;
      e_rd1 = e_v1 ? bus_rd : 32'h0;
      exp_v = {e_g0, e_g1, e_v0, e_v1, e_rd0, e_rd1, e_ba, e_bwd, e_we};
      got_v = act_vec(L);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_lat%0d cycle %0d: got %h expected %h", L, cyc, got_v, exp_v);
      end
    end
    // advance model to next cycle
    if (rst) begin
      owner = -1; last = 1; run = 0;
      hist = '{-1, -1, -1};
    end else begin
      r[0] = req0; r[1] = req1;
      gid = e_g0 ? 0 : (e_g1 ? 1 : -1);
      newtag = (gid >= 0 && !e_we) ? gid : -1;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = newtag;
      if (owner < 0) begin
        run = 0;
        if (r[0] && r[1]) owner = 1 - last;
        else if (r[0]) owner = 0;
        else if (r[1]) owner = 1;
      end else begin
        oth = 1 - owner;
        if (r[oth] && (!r[owner] || run == 3)) begin
          owner = oth; run = 0;
        end else if (!r[owner] && !r[oth]) begin
          owner = -1; run = 0;
        end else if (r[oth]) begin
          run++;
        end else begin
          run = 0;
        end
      end
      if (gid >= 0) last = gid;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  logic t4_req [13][2];

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wd0 = 32'h0; wd1 = 32'h0; bus_rd = 32'h0;
    next_cyc();
    next_cyc();
    mid();
    for (int L = 1; L <= 3; L++) chk($sformatf("reset_outs_lat%0d", L), 64'(|act_vec(L)), 64'h0);

    // T1: single read from m0
    next_cyc();
    rst = 1'b0; req0 = 1'b1; addr0 = 32'h1001_0000; we0 = 1'b0; bus_rd = 32'hDEAD_BEEF;
    mid();  chk("t1_no_gnt_yet", 64'(g0[1]), 64'h0);
    next_cyc();
    mid();  chk("t1_m0_gnt", 64'(g0[1]), 64'h1);
            chk("t1_bus_addr", 64'(ba[1]), 64'h1001_0000);
            chk("t1_bus_wren", 64'(bwe[1]), 64'h0);
    next_cyc(); req0 = 1'b0;
    mid();  chk("t1_m0_rdvalid", 64'(v0[1]), 64'h1);
            chk("t1_m0_rddata", 64'(rd0[1]), 64'hDEAD_BEEF);
            chk("t1_m1_quiet", {31'h0, v1[1], rd1[1]}, 64'h0);
            chk("t1_lat2_not_yet", 64'(v0[2]), 64'h0);
    next_cyc();
    mid();  chk("t1_lat2_rddata", {31'h0, v0[2], rd0[2]}, {31'h0, 1'b1, 32'hDEAD_BEEF});
    repeat (3) next_cyc();

    // T2: both request continuously after reset -> 4/4 alternation
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 32'h100; addr1 = 32'h200; wd0 = 32'h1; wd1 = 32'h2;
    mid();  chk("t2_no_gnt_yet", {62'h0, g1[1], g0[1]}, 64'h0);
    for (int k = 0; k < 12; k++) begin
      next_cyc();
      mid();
      chk($sformatf("t2_pattern_%0d", k), {62'h0, g1[1], g0[1]}, ((k % 8) < 4) ? 64'h1 : 64'h2);
    end
    next_cyc(); req0 = 1'b0; req1 = 1'b0;
    next_cyc();

    // T3: m1 alone writes for 10 cycles, no burst break
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1001_0004; wd1 = 32'h1234_5678;
    mid();  chk("t3_no_gnt_yet", 64'(g1[1]), 64'h0);
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      mid();
      chk($sformatf("t3_m1_write_%0d", k), {g1[1], bwe[1], ba[1], bwd[1][29:0]},
          {1'b1, 1'b1, 32'h1001_0004, 30'h1234_5678});
    end
    next_cyc(); req1 = 1'b0;
    next_cyc();

    // T4: interleaved reads, checked on the latency-3 instance
    t4_req = '{'{1'b1,1'b1}, '{1'b1,1'b1}, '{1'b0,1'b1}, '{1'b1,1'b1}, '{1'b1,1'b0},
               '{1'b1,1'b1}, '{1'b0,1'b1}, '{1'b0,1'b1}, '{1'b0,1'b0}, '{1'b0,1'b0},
               '{1'b0,1'b0}, '{1'b0,1'b0}, '{1'b0,1'b0}};
    addr0 = 32'h0040_0000; we0 = 1'b0; addr1 = 32'h1001_0000; we1 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) next_cyc();
      req0 = t4_req[c][0]; req1 = t4_req[c][1];
      bus_rd = 32'hA000_0000 + 32'(c);
      mid();
      if (c == 1) chk("t4_m0_gnt_addr", {31'h0, g0[3], ba[3]}, {31'h0, 1'b1, 32'h0040_0000});
      if (c == 3) chk("t4_m1_gnt_addr", {31'h0, g1[3], ba[3]}, {31'h0, 1'b1, 32'h1001_0000});
      if (c == 4) chk("t4_m0_rd_c4", {30'h0, v0[3], v1[3], rd0[3]}, {30'h0, 2'b10, 32'hA000_0004});
      if (c == 6) chk("t4_m1_rd_c6", {30'h0, v0[3], v1[3], rd1[3]}, {30'h0, 2'b01, 32'hA000_0006});
      if (c == 8) chk("t4_m0_rd_c8", {30'h0, v0[3], v1[3], rd0[3]}, {30'h0, 2'b10, 32'hA000_0008});
      if (c == 10) chk("t4_m1_rd_c10", {30'h0, v0[3], v1[3], rd1[3]}, {30'h0, 2'b01, 32'hA000_000A});
    end

    // T5: reset one cycle after a granted read discards it
    next_cyc(); req0 = 1'b1; req1 = 1'b0; addr0 = 32'h40; we0 = 1'b0; bus_rd = 32'h5555_AAAA;
    next_cyc();
    mid();  chk("t5_read_gnt", 64'(g0[2]), 64'h1);
    next_cyc(); rst = 1'b1;
    mid();
    for (int L = 1; L <= 3; L++) chk($sformatf("t5_rst_outs_lat%0d", L), 64'(|act_vec(L)), 64'h0);
    next_cyc(); rst = 1'b0; req0 = 1'b0;
    mid();
    for (int L = 1; L <= 3; L++) chk($sformatf("t5_no_rdvalid_a_lat%0d", L), {62'h0, v0[L], v1[L]}, 64'h0);
    next_cyc();
    mid();
    for (int L = 1; L <= 3; L++) chk($sformatf("t5_no_rdvalid_b_lat%0d", L), {62'h0, v0[L], v1[L]}, 64'h0);
    next_cyc(); req0 = 1'b1; we0 = 1'b1;
    mid();  chk("t5_idle_after_rst", 64'(g0[2]), 64'h0);
    next_cyc();
    mid();  chk("t5_first_gnt", 64'(g0[2]), 64'h1);
    next_cyc(); req0 = 1'b0;

    // T6: owner drops while other raises -> other granted next cycle
    next_cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wd0 = 32'h11;
    next_cyc();
    mid();  chk("t6_m0_gnt", 64'(g0[1]), 64'h1);
    next_cyc(); req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h24; wd1 = 32'h22;
    mid();  chk("t6_handoff_cycle", {62'h0, g1[1], g0[1]}, 64'h0);
    next_cyc();
    mid();  chk("t6_m1_gnt", {62'h0, g1[1], g0[1]}, 64'h2);
    next_cyc(); req1 = 1'b0;
    next_cyc();
    mid();  chk("t6_idle_bus", {bwe[1], ba[1][30:0], bwd[1]}, 64'h0);
    repeat (3) next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
